// File: rtl/op_rate_monitor.sv
// op_rate_monitor
// Counts completed crypto operations over a window of N seconds, where the
// seconds come from an external tick generator that this block enables and
// clears. The count from the last completed window is published on result_o.
//
// Ports
//   clk             single clock, all logic on the rising edge
//   rst_i           synchronous active-high reset
//   start_i         one-cycle request to begin a window (ignored while busy)
//   abort_i         cancels an in-progress window (ARM or MEASURE only)
//   window_i        window length in seconds, sampled in ARM (0 means 1)
//   op_done_i       one-cycle pulse per completed operation
//   second_tick_i   one-cycle pulse from the one-second tick generator
//   timer_en_o      enable to the tick generator (high in MEASURE)
//   timer_rst_o     clear pulse to the tick generator (high in ARM)
//   busy_o          high whenever the FSM is not IDLE
//   result_valid_o  one-cycle pulse when result_o/overflow_o update
//   result_o        operation count of the last completed window
//   overflow_o      count saturated during the last completed window
module op_rate_monitor #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [7:0]         window_i,
  input  logic               op_done_i,
  input  logic               second_tick_i,
  output logic               timer_en_o,
  output logic               timer_rst_o,
  output logic               busy_o,
  output logic               result_valid_o,
  output logic [COUNT_W-1:0] result_o,
  output logic               overflow_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  state_t             state_reg, state_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic               ovf_reg, ovf_next;
  logic [7:0]         secs_reg, secs_next;

  logic               timer_en_reg, timer_rst_reg, busy_reg, valid_reg;
  logic [COUNT_W-1:0] result_reg;
  logic               overflow_reg;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    secs_next  = secs_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) state_next = ARM;
      end
      ARM: begin
        count_next = '0;
        ovf_next   = 1'b0;
        secs_next  = (window_i == 8'd0) ? 8'd1 : window_i;
        state_next = abort_i ? IDLE : MEASURE;
      end
      MEASURE: begin
        // An op in the same cycle as the final tick still belongs to this
        // window, so counting happens before the tick decision.
        if (op_done_i) begin
          if (count_reg == COUNT_MAX) ovf_next = 1'b1;
          else                        count_next = count_reg + 1'b1;
        end
        if (abort_i) begin
          state_next = IDLE;
        end else if (second_tick_i) begin
          if (secs_reg > 8'd1) secs_next = secs_reg - 8'd1;
          else                 state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they line up with
  // the state they describe without any combinational path to the pins.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
      secs_reg      <= 8'd0;
      timer_en_reg  <= 1'b0;
      timer_rst_reg <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      result_reg    <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      ovf_reg       <= ovf_next;
      secs_reg      <= secs_next;
      timer_en_reg  <= (state_next == MEASURE);
      timer_rst_reg <= (state_next == ARM);
      busy_reg      <= (state_next != IDLE);
      valid_reg     <= (state_next == DONE);
      // Capture the count including any op coincident with the final tick.
      if (state_next == DONE) begin
        result_reg   <= count_next;
        overflow_reg <= ovf_next;
      end
    end
  end

  assign timer_en_o     = timer_en_reg;
  assign timer_rst_o    = timer_rst_reg;
  assign busy_o         = busy_reg;
  assign result_valid_o = valid_reg;
  assign result_o       = result_reg;
  assign overflow_o     = overflow_reg;

endmodule

// File: tb/tb_op_rate_monitor.sv
// Testbench for op_rate_monitor (COUNT_W = 4 so saturation is reachable).
// Stimulus pushes the expected published result into a queue; a monitor
// pops and compares on every result_valid_o pulse.
module tb_op_rate_monitor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [7:0]   window_i = 8'd0;
  logic         op_done_i = 1'b0;
  logic         second_tick_i = 1'b0;
  logic         timer_en_o, timer_rst_o, busy_o, result_valid_o, overflow_o;
  logic [W-1:0] result_o;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  op_rate_monitor #(.COUNT_W(W)) dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .window_i       (window_i),
    .op_done_i      (op_done_i),
    .second_tick_i  (second_tick_i),
    .timer_en_o     (timer_en_o),
    .timer_rst_o    (timer_rst_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ops(input int n);
    op_done_i = 1'b1;
    cyc(n);
    op_done_i = 1'b0;
  endtask

  task automatic tick();
    second_tick_i = 1'b1;
    cyc(1);
    second_tick_i = 1'b0;
  endtask

  // start at N; returns at the falling edge inside the ARM cycle
  task automatic start_window(input logic [7:0] w);
    window_i = w;
    start_i  = 1'b1;
    cyc(1);
    start_i  = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_timer_en"},  timer_en_o,     0);
    check({tag, "_timer_rst"}, timer_rst_o,    0);
    check({tag, "_busy"},      busy_o,         0);
    check({tag, "_valid"},     result_valid_o, 0);
    check({tag, "_result"},    result_o,       0);
    check({tag, "_overflow"},  overflow_o,     0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (result_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0d required=no_pulse", result_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("result: got %0d/%0d expected %0d/%0d", result_o, overflow_o, e.res, e.ovf);
        check("result_o", result_o, e.res);
        check("overflow_o", overflow_o, e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    rst_i = 1'b0;
    check_idle_zero("reset");

    // abort in IDLE is ignored
    abort_i = 1'b1; cyc(1); abort_i = 1'b0;
    check("idle_abort_busy", busy_o, 0);

    // Window 2: 5 ops, tick, 3 ops, tick -> 8; plus ARM/MEASURE timing
    start_window(8'd2);
    check("arm_timer_rst", timer_rst_o, 1);
    check("arm_timer_en",  timer_en_o,  0);
    check("arm_busy",      busy_o,      1);
    cyc(1);
    check("meas_timer_rst", timer_rst_o, 0);
    check("meas_timer_en",  timer_en_o,  1);
    exp_q.push_back('{res: 4'd8, ovf: 1'b0});
    ops(5);
    tick();
    check("meas_after_tick1_en", timer_en_o, 1);
    ops(3);
    tick();
    check("done_valid",    result_valid_o, 1);
    check("done_timer_en", timer_en_o,     0);
    cyc(1);
    check("after_done_busy",  busy_o,         0);
    check("after_done_valid", result_valid_o, 0);

    // Window 0 (as 1): 2 ops then op coincident with the tick -> 3;
    // abort during DONE is ignored
    start_window(8'd0);
    cyc(1);
    exp_q.push_back('{res: 4'd3, ovf: 1'b0});
    ops(2);
    op_done_i = 1'b1; second_tick_i = 1'b1; cyc(1);
    op_done_i = 1'b0; second_tick_i = 1'b0;
    abort_i = 1'b1; cyc(1); abort_i = 1'b0;
    check("abort_in_done_result", result_o, 3);
    cyc(1);

    // Saturation: 20 ops in a 4-bit counter -> 15, overflow
    start_window(8'd1);
    cyc(1);
    exp_q.push_back('{res: 4'd15, ovf: 1'b1});
    ops(20);
    tick();
    cyc(1);
    // Next window: op during ARM ignored, 2 ops -> 2, overflow cleared
    start_window(8'd1);
    op_done_i = 1'b1; cyc(1); op_done_i = 1'b0;
    exp_q.push_back('{res: 4'd2, ovf: 1'b0});
    ops(2);
    tick();
    cyc(1);

    // Establish result 7, then abort a window after 4 ops
    start_window(8'd1);
    cyc(1);
    exp_q.push_back('{res: 4'd7, ovf: 1'b0});
    ops(7);
    tick();
    cyc(1);
    start_window(8'd3);
    cyc(1);
    ops(4);
    abort_i = 1'b1; cyc(1); abort_i = 1'b0;
    check("abort_busy",     busy_o,     0);
    check("abort_timer_en", timer_en_o, 0);
    check("abort_result",   result_o,   7);
    tick(); tick(); tick();
    check("abort_hold_result", result_o, 7);

    // Second start during MEASURE is ignored, then reset mid-MEASURE
    start_window(8'd3);
    cyc(1);
    ops(2);
    start_i = 1'b1; cyc(1); start_i = 1'b0;
    check("restart_ignored_rst", timer_rst_o, 0);
    check("restart_ignored_en",  timer_en_o,  1);
    tick();
    rst_i = 1'b1; start_i = 1'b1; abort_i = 1'b1; cyc(1);
    rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    check_idle_zero("midrst");
    tick(); tick(); tick();
    check("post_rst_busy", busy_o, 0);

    cyc(3);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/op_rate_monitor.md
OP_RATE_MONITOR -- requirements
Module: op_rate_monitor

Interface
REQ-001 SHALL have parameter COUNT_W, default 32, width of the operation counter and result.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_i  input  1  single-cycle request to begin a measurement window.
REQ-005 SHALL have port abort_i  input  1  cancel an in-progress measurement.
REQ-006 SHALL have port window_i  input  8  window length in seconds, sampled at start; 0 treated as 1.
REQ-007 SHALL have port op_done_i  input  1  one-cycle pulse per completed crypto operation.
REQ-008 SHALL have port second_tick_i  input  1  one-cycle tick from the external one-second tick generator.
REQ-009 SHALL have port timer_en_o  output  1  enable to the tick generator.
REQ-010 SHALL have port timer_rst_o  output  1  clear pulse to the tick generator.
REQ-011 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-012 SHALL have port result_valid_o  output  1  one-cycle pulse when result_o updates.
REQ-013 SHALL have port result_o  output  COUNT_W  operations counted in the last completed window.
REQ-014 SHALL have port overflow_o  output  1  sticky flag: count saturated in the last completed window.

Function
REQ-015 SHALL implement FSM states IDLE, ARM, MEASURE, DONE; all outputs registered.
REQ-016 IDLE: start_i=1 SHALL transition to ARM next cycle; abort_i SHALL be ignored in IDLE.
REQ-017 ARM (exactly one cycle): timer_rst_o=1, timer_en_o=0, op counter cleared to 0, overflow flag cleared, seconds-remaining loaded from window_i (0 -> 1); next state MEASURE.
REQ-018 MEASURE: timer_en_o=1, timer_rst_o=0; each op_done_i=1 cycle increments the counter by 1.
REQ-019 Counter SHALL saturate at 2^COUNT_W-1 and set the internal overflow flag; no wrap-around.
REQ-020 MEASURE: second_tick_i=1 with seconds-remaining > 1 SHALL decrement seconds-remaining; with seconds-remaining == 1 SHALL transition to DONE.
REQ-021 op_done_i coincident with the final second_tick_i SHALL be counted.
REQ-022 op_done_i and second_tick_i in IDLE, ARM or DONE SHALL be ignored.
REQ-023 DONE (exactly one cycle): result_o <= counter, overflow_o <= overflow flag, result_valid_o=1, timer_en_o=0; next state IDLE.
REQ-024 result_o and overflow_o SHALL hold their values until the next DONE or reset.
REQ-025 start_i while busy_o=1 SHALL be ignored (no restart, no queuing).
REQ-026 abort_i in ARM or MEASURE SHALL return to IDLE next cycle with timer_en_o=0; result_o, overflow_o unchanged; no result_valid_o pulse.
REQ-027 abort_i in DONE SHALL be ignored; the result SHALL still be published.
REQ-028 Latency: start_i at cycle N -> ARM at N+1, timer_en_o=1 from N+2; result_valid_o exactly one cycle after the final tick is sampled.

Reset
REQ-029 rst_i=1 at a clock edge SHALL force IDLE from any state, including mid-MEASURE.
REQ-030 Reset values: timer_en_o=0, timer_rst_o=0, busy_o=0, result_valid_o=0, result_o=0, overflow_o=0, counter=0, seconds-remaining=0.
REQ-031 rst_i SHALL take priority over start_i and abort_i in the same cycle.

Verification
REQ-032 window_i=2, start, 5 op_done pulses before tick 1, 3 before tick 2 -> result_valid_o one cycle after tick 2, result_o=8, overflow_o=0.
REQ-033 window_i=0, start, op_done on same cycle as tick 1 plus 2 earlier -> window ends on tick 1, result_o=3.
REQ-034 COUNT_W=4, window_i=1, 20 op_done pulses -> result_o=15, overflow_o=1; next window with 2 ops -> result_o=2, overflow_o=0.
REQ-035 Previous result 7; start, 4 ops, abort_i mid-MEASURE -> IDLE next cycle, timer_en_o=0, no result_valid_o, result_o stays 7.
REQ-036 start_i pulsed during MEASURE, and rst_i asserted mid-MEASURE -> second start has no effect; reset yields all outputs 0 and IDLE next cycle.
REQ-037 Timing: start at cycle N -> timer_rst_o=1 at N+1 only, timer_en_o=1 from N+2 until DONE.
